i2s_sample_feeder: RTL and testbench

Buffers 16-bit audio samples from the sample producer and presents one word at a time to the serializer stage (the bit shifter driving the I2S data line). Each word-boundary request from the serializer pops the next sample and updates the left/right channel tag. An empty FIFO at a request produces a mute word (zero) and an underrun flag, so L/R framing is never lost.

---
 rtl/i2s_pkg.sv | 7 +
 rtl/sample_fifo_mem.sv | 48 ++++
 rtl/i2s_sample_feeder.sv | 104 ++++++++++
 tb/tb_i2s_sample_feeder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: sample width, channel encoding and the mute word.
package i2s_pkg;
    localparam int unsigned          SAMPLE_W  = 16;
    localparam logic                 CH_LEFT   = 1'b0;
    localparam logic                 CH_RIGHT  = 1'b1;
    localparam logic [SAMPLE_W-1:0]  MUTE_WORD = '0;
endpackage

// File: rtl/sample_fifo_mem.sv
// DEPTH x WIDTH sample store with one write port and one registered read port.
// The read register doubles as the feeder's output word and can be cleared to mute.
module sample_fifo_mem
    import i2s_pkg::*;
#(
    parameter int unsigned WIDTH = SAMPLE_W,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic                     rd_clr,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_clr) begin
            rd_data_d = WIDTH'(MUTE_WORD);
        end else if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/i2s_sample_feeder.sv
// Sample FIFO between the audio producer and the I2S serializer; every word
// request pops a sample (or a mute word on underrun) and flips the L/R tag.
module i2s_sample_feeder
    import i2s_pkg::*;
#(
    parameter int unsigned WIDTH = SAMPLE_W,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   word_req,
    input  logic                   flush,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_channel,
    output logic                   underrun,
    output logic [$clog2(DEPTH):0] level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          out_channel_q, out_channel_d;
    logic          underrun_q, underrun_d;
    logic          push, pop_req, pop, empty, rd_clr;

    // Readiness depends only on the registered count: no pass-through when full.
    assign in_ready = (count_q != CW'(DEPTH));

    always_comb begin
        empty         = (count_q == '0);
        push          = in_valid && in_ready && !flush;
        pop_req       = word_req && !flush;
        pop           = pop_req && !empty;
        rd_clr        = flush || (pop_req && empty);
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        out_channel_d = out_channel_q;
        underrun_d    = 1'b0;
        if (flush) begin
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
            out_channel_d = CH_RIGHT;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (pop_req) begin
                out_channel_d = ~out_channel_q;
                underrun_d    = empty;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Channel resets to right so the first request after a clear is left.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            out_channel_q <= CH_RIGHT;
            underrun_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            out_channel_q <= out_channel_d;
            underrun_q    <= underrun_d;
        end
    end

    sample_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_clr  (rd_clr),
        .rd_addr (rd_ptr_q),
        .rd_data (out_data)
    );

    assign out_channel = out_channel_q;
    assign underrun    = underrun_q;
    assign level       = count_q;
endmodule

// File: tb/tb_i2s_sample_feeder.sv
// Directed bench for i2s_sample_feeder: hand-computed checks plus a small queue scoreboard.
module tb_i2s_sample_feeder;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned DEPTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             word_req;
    logic             flush;
    logic [WIDTH-1:0] out_data;
    logic             out_channel;
    logic             underrun;
    logic [3:0]       level;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] exp_out;
    logic             exp_ch;
    logic             exp_under;

    i2s_sample_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .word_req    (word_req),
        .flush       (flush),
        .out_data    (out_data),
        .out_channel (out_channel),
        .underrun    (underrun),
        .level       (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next falling edge.
    task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f);
        logic push_ok;
        in_valid = v;
        in_data  = d;
        word_req = r;
        flush    = f;
        push_ok  = v && !f && (model_q.size() < DEPTH);
        @(posedge clk);
        @(negedge clk);
        if (f) begin
            model_q.delete();
            exp_out   = '0;
            exp_ch    = 1'b1;
            exp_under = 1'b0;
        end else begin
            exp_under = 1'b0;
            if (r) begin
                exp_ch = ~exp_ch;
                if (model_q.size() > 0) begin
                    exp_out = model_q.pop_front();
                end else begin
                    exp_out   = '0;
                    exp_under = 1'b1;
                end
            end
            if (push_ok) model_q.push_back(d);
        end
        in_valid = 1'b0;
        word_req = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".data"},  32'(out_data),    32'(exp_out));
        check({tag, ".ch"},    32'(out_channel), 32'(exp_ch));
        check({tag, ".under"}, 32'(underrun),    32'(exp_under));
        check({tag, ".level"}, 32'(level),       32'(model_q.size()));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_q.delete();
        exp_out = '0; exp_ch = 1'b1; exp_under = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_data = '0; in_valid = 1'b0; word_req = 1'b0; flush = 1'b0;
        do_reset();
        check("rst.data",  32'(out_data), 32'h0);
        check("rst.ch",    32'(out_channel), 32'h1);
        check("rst.under", 32'(underrun), 32'h0);
        check("rst.level", 32'(level), 32'h0);
        check("rst.ready", 32'(in_ready), 32'h1);

        // Request with nothing pushed: mute word, single-cycle underrun.
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("mute.data",  32'(out_data), 32'h0);
        check("mute.under", 32'(underrun), 32'h1);
        check("mute.ch",    32'(out_channel), 32'h0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("mute.pulse", 32'(underrun), 32'h0);

        // Two pushes, two back-to-back requests.
        do_reset();
        cyc(1'b1, 16'h1111, 1'b0, 1'b0);
        cyc(1'b1, 16'h2222, 1'b0, 1'b0);
        check("two.level", 32'(level), 32'h2);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("two.d0", 32'(out_data), 32'h1111);
        check("two.c0", 32'(out_channel), 32'h0);
        check("two.u0", 32'(underrun), 32'h0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("two.d1", 32'(out_data), 32'h2222);
        check("two.c1", 32'(out_channel), 32'h1);
        check("two.l1", 32'(level), 32'h0);
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("two.hold", 32'(out_data), 32'h2222);

        // Fill to full; held sample waits until a pop frees a slot.
        for (int i = 0; i < 8; i++) cyc(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
        check("full.level", 32'(level), 32'h8);
        check("full.ready", 32'(in_ready), 32'h0);
        cyc(1'b1, 16'hDEAD, 1'b0, 1'b0);
        check("full.noacc", 32'(level), 32'h8);
        cyc(1'b1, 16'hDEAD, 1'b1, 1'b0);
        check("full.pop.level", 32'(level), 32'h7);
        check("full.pop.ready", 32'(in_ready), 32'h1);
        check("full.pop.data",  32'(out_data), 32'h0100);
        check("full.pop.ch",    32'(out_channel), 32'h0);
        cyc(1'b1, 16'hDEAD, 1'b0, 1'b0);
        check("full.acc", 32'(level), 32'h8);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, '0, 1'b1, 1'b0);
            check_model("drain");
        end
        check("drain.last", 32'(out_data), 32'hDEAD);
        check("drain.lastch", 32'(out_channel), 32'h0);

        // Level 3 with simultaneous push and pop for 20 cycles.
        for (int i = 0; i < 3; i++) cyc(1'b1, 16'(16'h3000 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 16'(16'h3003 + i), 1'b1, 1'b0);
            check_model("pp");
            check("pp.level3", 32'(level), 32'h3);
        end
        check("pp.last", 32'(out_data), 32'h3013);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0);
        check("pp.empty", 32'(level), 32'h0);

        // Empty: push and request together gives mute, sample is stored.
        cyc(1'b1, 16'hABCD, 1'b1, 1'b0);
        check("eb.data",  32'(out_data), 32'h0);
        check("eb.under", 32'(underrun), 32'h1);
        check("eb.level", 32'(level), 32'h1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("eb.data2",  32'(out_data), 32'hABCD);
        check("eb.under2", 32'(underrun), 32'h0);

        // Level 5, left channel showing, then flush with push and request.
        for (int i = 0; i < 6; i++) cyc(1'b1, 16'(16'h5000 + i), 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("fl.pre.level", 32'(level), 32'h5);
        check("fl.pre.ch",    32'(out_channel), 32'h0);
        check("fl.pre.data",  32'(out_data), 32'h5000);
        cyc(1'b1, 16'h7777, 1'b1, 1'b1);
        check("fl.level", 32'(level), 32'h0);
        check("fl.data",  32'(out_data), 32'h0);
        check("fl.ch",    32'(out_channel), 32'h1);
        check("fl.under", 32'(underrun), 32'h0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("fl.next.ch",    32'(out_channel), 32'h0);
        check("fl.next.under", 32'(underrun), 32'h1);
        check("fl.next.data",  32'(out_data), 32'h0);

        // After flush, the first sample pushed is the next word out.
        cyc(1'b1, 16'h4242, 1'b0, 1'b1);
        cyc(1'b1, 16'h4343, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check_model("post");
        check("post.data", 32'(out_data), 32'h4343);
        check("post.ch",   32'(out_channel), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
